// File: rtl/wb_port_arbiter.sv
// Shares one register-file write port between the unbuffered ALU writeback and a buffered load-return FIFO.
// Optional build macro WB_R0_DISCARD_EN: granted requests targeting register 0 are consumed without a write strobe.
module wb_port_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SEL_W  = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [SEL_W-1:0]  a_sel,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [SEL_W-1:0]  m_sel,
    input  logic [DATA_W-1:0] m_data,
    output logic              wr_en,
    output logic [SEL_W-1:0]  wr_sel,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    wb_req_t           mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              last_alu_q, last_alu_d;
    logic              wr_en_q, wr_en_d;
    logic [SEL_W-1:0]  wr_sel_q, wr_sel_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic    full, head_v, push, pop;
    logic    grant_alu, grant_fifo;
    wb_req_t winner;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign head_v  = (count_q != '0);
    assign m_ready = ~full;
    assign push    = m_valid & ~full;
    assign pop     = grant_fifo;
    assign a_ready = grant_alu;
    assign busy    = head_v;
    assign wr_en   = wr_en_q;
    assign wr_sel  = wr_sel_q;
    assign wr_data = wr_data_q;

    // Round-robin between ALU and FIFO head; a full FIFO overrides fairness.
    always_comb begin
        grant_alu  = 1'b0;
        grant_fifo = 1'b0;
        if (full) begin
            grant_fifo = 1'b1;
        end else if (head_v && a_valid) begin
            if (last_alu_q) grant_fifo = 1'b1;
            else            grant_alu  = 1'b1;
        end else if (a_valid) begin
            grant_alu = 1'b1;
        end else if (head_v) begin
            grant_fifo = 1'b1;
        end
    end

    always_comb begin
        winner = grant_fifo ? mem_q[rd_ptr_q] : wb_req_t'{sel: a_sel, data: a_data};
    end

    // Pointer, count, fairness and output-stage next state.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        last_alu_d = last_alu_q;
        wr_en_d    = 1'b0;
        wr_sel_d   = wr_sel_q;
        wr_data_d  = wr_data_q;

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (grant_alu)  last_alu_d = 1'b1;
        if (grant_fifo) last_alu_d = 1'b0;

        if (grant_alu || grant_fifo) begin
`ifdef WB_R0_DISCARD_EN
            if (winner.sel != '0) begin
                wr_en_d   = 1'b1;
                wr_sel_d  = winner.sel;
                wr_data_d = winner.data;
            end
`else
            wr_en_d   = 1'b1;
            wr_sel_d  = winner.sel;
            wr_data_d = winner.data;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            last_alu_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_sel_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            last_alu_q <= last_alu_d;
            wr_en_q    <= wr_en_d;
            wr_sel_q   <= wr_sel_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wb_req_t'{sel: m_sel, data: m_data};
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a cycle table of inputs and expected outputs plus reset and register-0 sequences.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        a_valid;
    logic        a_ready;
    logic [3:0]  a_sel;
    logic [31:0] a_data;
    logic        m_valid;
    logic        m_ready;
    logic [3:0]  m_sel;
    logic [31:0] m_data;
    logic        wr_en;
    logic [3:0]  wr_sel;
    logic [31:0] wr_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    wb_port_arbiter #(.DATA_W(32), .SEL_W(4), .DEPTH(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_sel   (a_sel),
        .a_data  (a_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_sel   (m_sel),
        .m_data  (m_data),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_data (wr_data),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [3:0]  asel;
        logic [31:0] adat;
        logic        mv;
        logic [3:0]  msel;
        logic [31:0] mdat;
        logic        ar;
        logic        mr;
        logic        wen;
        logic [3:0]  wsel;
        logic [31:0] wdat;
        logic        bsy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add_vec(input logic av, input logic [3:0] asel, input logic [31:0] adat,
                                    input logic mv, input logic [3:0] msel, input logic [31:0] mdat,
                                    input logic ar, input logic mr,
                                    input logic wen, input logic [3:0] wsel, input logic [31:0] wdat,
                                    input logic bsy);
        vec_t v;
        v.av = av; v.asel = asel; v.adat = adat;
        v.mv = mv; v.msel = msel; v.mdat = mdat;
        v.ar = ar; v.mr = mr;
        v.wen = wen; v.wsel = wsel; v.wdat = wdat; v.bsy = bsy;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] asel, input logic [31:0] adat,
                         input logic mv, input logic [3:0] msel, input logic [31:0] mdat);
        a_valid = av; a_sel = asel; a_data = adat;
        m_valid = mv; m_sel = msel; m_data = mdat;
    endtask

    task automatic check_regs(input string tag, input logic wen, input logic [3:0] wsel,
                              input logic [31:0] wdat, input logic bsy);
        check({tag, ".wr_en"},   32'(wr_en),   32'(wen));
        check({tag, ".wr_sel"},  32'(wr_sel),  32'(wsel));
        check({tag, ".wr_data"}, wr_data,      wdat);
        check({tag, ".busy"},    32'(busy),    32'(bsy));
    endtask

    initial begin
        // av asel adat          mv msel mdat         ar mr  wen wsel wdat        busy
        add_vec(1, 5, 32'hDEADBEEF, 0, 0, 0,          1, 1,  1, 5, 32'hDEADBEEF, 0);
        add_vec(0, 0, 0,            0, 0, 0,          0, 1,  0, 5, 32'hDEADBEEF, 0);
        add_vec(0, 0, 0,            1, 3, 32'h11,     0, 1,  0, 5, 32'hDEADBEEF, 1);
        add_vec(0, 0, 0,            1, 4, 32'h22,     0, 1,  1, 3, 32'h11,       1);
        add_vec(0, 0, 0,            0, 0, 0,          0, 1,  1, 4, 32'h22,       0);
        add_vec(0, 0, 0,            0, 0, 0,          0, 1,  0, 4, 32'h22,       0);
        add_vec(0, 0, 0,            1, 9, 32'h99,     0, 1,  0, 4, 32'h22,       1);
        add_vec(1, 1, 32'h101,      1, 10, 32'hAA,    1, 1,  1, 1, 32'h101,      1);
        add_vec(1, 2, 32'h102,      0, 0, 0,          0, 0,  1, 9, 32'h99,       1);
        add_vec(1, 2, 32'h102,      0, 0, 0,          1, 1,  1, 2, 32'h102,      1);
        add_vec(1, 3, 32'h103,      0, 0, 0,          0, 1,  1, 10, 32'hAA,      0);
        add_vec(1, 3, 32'h103,      0, 0, 0,          1, 1,  1, 3, 32'h103,      0);
        add_vec(0, 0, 0,            0, 0, 0,          0, 1,  0, 3, 32'h103,      0);
        add_vec(0, 0, 0,            1, 6, 32'h66,     0, 1,  0, 3, 32'h103,      1);
        add_vec(1, 7, 32'h77,       1, 11, 32'hBB,    0, 1,  1, 6, 32'h66,       1);
        add_vec(1, 7, 32'h77,       1, 12, 32'hCC,    1, 1,  1, 7, 32'h77,       1);
        add_vec(1, 8, 32'h88,       1, 13, 32'hDD,    0, 0,  1, 11, 32'hBB,      1);
        add_vec(1, 8, 32'h88,       1, 13, 32'hDD,    1, 1,  1, 8, 32'h88,       1);
        add_vec(0, 0, 0,            0, 0, 0,          0, 0,  1, 12, 32'hCC,      1);
        add_vec(0, 0, 0,            0, 0, 0,          0, 1,  1, 13, 32'hDD,      0);
        add_vec(0, 0, 0,            0, 0, 0,          0, 1,  0, 13, 32'hDD,      0);

        // Reset state, and ALU priority visible on a_ready while held in reset.
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        #12;
        check_regs("reset", 0, 0, 0, 0);
        check("reset.m_ready", 32'(m_ready), 32'd1);
        a_valid = 1'b1;
        #1;
        check("reset.a_ready", 32'(a_ready), 32'd1);
        @(negedge clk);
        a_valid = 1'b0;
        rst_n   = 1'b1;

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].av, vecs[i].asel, vecs[i].adat, vecs[i].mv, vecs[i].msel, vecs[i].mdat);
            #1;
            check($sformatf("v%0d.a_ready", i), 32'(a_ready), 32'(vecs[i].ar));
            check($sformatf("v%0d.m_ready", i), 32'(m_ready), 32'(vecs[i].mr));
            @(posedge clk);
            #1;
            check_regs($sformatf("v%0d", i), vecs[i].wen, vecs[i].wsel, vecs[i].wdat, vecs[i].bsy);
        end

        // Two loads queued and an ALU write in flight, then async reset mid-cycle.
        @(negedge clk);
        drive(0, 0, 0, 1, 14, 32'hE1);
        @(negedge clk);
        drive(1, 2, 32'h202, 1, 15, 32'hE2);
        @(posedge clk);
        #1;
        check_regs("prerst", 1, 2, 32'h202, 1);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_regs("midrst", 0, 0, 0, 0);
        check("midrst.m_ready", 32'(m_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            check_regs($sformatf("postrst%0d", c), 0, 0, 0, 0);
        end

        // Register-0 request followed by an ordinary one.
        @(negedge clk);
        drive(1, 0, 32'h5A5A, 0, 0, 0);
        #1;
        check("r0.a_ready", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
`ifdef WB_R0_DISCARD_EN
        check_regs("r0", 0, 0, 0, 0);
`else
        check_regs("r0", 1, 0, 32'h5A5A, 0);
`endif
        @(negedge clk);
        drive(1, 1, 32'h1111, 0, 0, 0);
        #1;
        check("r1.a_ready", 32'(a_ready), 32'd1);
        @(posedge clk);
        #1;
        check_regs("r1", 1, 1, 32'h1111, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        check_regs("r1idle", 0, 1, 32'h1111, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
